column_assembler: RTL and testbench

COLUMN_ASSEMBLER -- requirements
Module: column_assembler

---
 rtl/column_assembler_pkg.sv | 28 ++
 rtl/pixel_shift_fill.sv | 72 +++++++
 rtl/column_assembler.sv | 142 ++++++++++++++
 tb/tb_column_assembler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/column_assembler_pkg.sv
// Shared definitions for the column assembler and the convolution stage:
// image geometry defaults and the frame sequencer / hold state encodings.
package column_assembler_pkg;

    // Image geometry defaults, common with the convolution stage.
    localparam int unsigned ImgHeightDefault = 120;
    localparam int unsigned ImgNbDefault     = 7;
    localparam int unsigned ImgWidthDefault  = 160;

    // Frame sequencer: left pad column, data columns, right pad column.
    typedef enum logic [1:0] {
        SeqPadL = 2'd0,
        SeqData = 2'd1,
        SeqPadR = 2'd2
    } seq_state_t;

    // Hold register occupancy.
    typedef enum logic {
        HoldEmpty = 1'b0,
        HoldFull  = 1'b1
    } hold_state_t;

    // Counter width that stays legal for a range of a single value.
    function automatic int unsigned cnt_width(input int unsigned range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/pixel_shift_fill.sv
// Fill register for one image column: pixels arrive serially, top row first,
// and are stored bit-exact at the slot given by the pixel counter. Row 0 sits
// in the MSB slice. The register is marked full after the last row and stays
// full until the sequencer takes it.
module pixel_shift_fill
    import column_assembler_pkg::*;
#(
    parameter int unsigned IMG_HEIGHT = ImgHeightDefault,
    parameter int unsigned IMG_NB     = ImgNbDefault
) (
    input  logic                         clock,
    input  logic                         i_reset,
    input  logic [IMG_NB-1:0]            i_pixel,
    input  logic                         i_valid,
    input  logic                         i_take,
    output logic                         o_ready,
    output logic                         o_full,
    output logic [IMG_HEIGHT*IMG_NB-1:0] o_fill
);

    localparam int unsigned CntW = cnt_width(IMG_HEIGHT);
    localparam logic [CntW-1:0] LastRow = CntW'(IMG_HEIGHT - 1);

    logic [IMG_HEIGHT*IMG_NB-1:0] fill_q, fill_d;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic                         full_q, full_d;
    logic                         accept;

    // A take in this cycle empties the register, so a pixel may land at slot 0
    // in the same cycle without stalling the stream.
    assign o_ready = ~full_q | i_take;
    assign accept  = i_valid & o_ready;
    assign o_full  = full_q;
    assign o_fill  = fill_q;

    // Next-state: slot write, counter advance and full flag.
    always_comb begin
        fill_d = fill_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (i_take) begin
            full_d = 1'b0;
        end
        if (accept) begin
            for (int s = 0; s < int'(IMG_HEIGHT); s++) begin
                if (cnt_q == CntW'(s)) begin
                    fill_d[(int'(IMG_HEIGHT) - s) * int'(IMG_NB) - 1 -: IMG_NB] = i_pixel;
                end
            end
            if (cnt_q == LastRow) begin
                cnt_d  = '0;
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // State register with synchronous reset; partial columns are discarded.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            fill_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

endmodule

// File: rtl/column_assembler.sv
// Column assembler: collects a serial pixel stream into columns and presents
// them, framed by a zero column on each side, to the convolution stage. The
// fill register (sub-module) collects pixels; the hold register drives o_col.
// Every load of the hold register pulses o_control; the right pad column also
// pulses o_frame_end.
module column_assembler
    import column_assembler_pkg::*;
#(
    parameter int unsigned IMG_HEIGHT = ImgHeightDefault,
    parameter int unsigned IMG_NB     = ImgNbDefault,
    parameter int unsigned IMG_WIDTH  = ImgWidthDefault
) (
    input  logic                         clock,
    input  logic                         i_reset,
    input  logic [IMG_NB-1:0]            i_pixel,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic [IMG_HEIGHT*IMG_NB-1:0] o_col,
    output logic                         o_control,
    output logic                         o_col_pad,
    output logic                         o_frame_end,
    input  logic                         i_col_ack
);

    localparam int unsigned ColBits = IMG_HEIGHT * IMG_NB;
    localparam int unsigned ColW    = cnt_width(IMG_WIDTH);
    localparam logic [ColW-1:0] LastCol = ColW'(IMG_WIDTH - 1);

    seq_state_t   seq_q, seq_d;
    hold_state_t  hold_q, hold_d;
    logic [ColBits-1:0] col_q, col_d;
    logic [ColW-1:0]    col_cnt_q, col_cnt_d;
    logic         pad_q, pad_d;
    logic         control_q, control_d;
    logic         frame_end_q, frame_end_d;

    logic               take;
    logic               fill_full;
    logic [ColBits-1:0] fill_col;
    logic               hold_free;

    pixel_shift_fill #(
        .IMG_HEIGHT (IMG_HEIGHT),
        .IMG_NB     (IMG_NB)
    ) u_fill (
        .clock   (clock),
        .i_reset (i_reset),
        .i_pixel (i_pixel),
        .i_valid (i_valid),
        .i_take  (take),
        .o_ready (o_ready),
        .o_full  (fill_full),
        .o_fill  (fill_col)
    );

    // An ack in the same cycle frees the hold register for a new load.
    assign hold_free = (hold_q == HoldEmpty) | i_col_ack;

    // Sequencer next-state: pad / data loads into hold and hold occupancy.
    always_comb begin
        seq_d       = seq_q;
        hold_d      = hold_q;
        col_d       = col_q;
        col_cnt_d   = col_cnt_q;
        pad_d       = pad_q;
        control_d   = 1'b0;
        frame_end_d = 1'b0;
        take        = 1'b0;

        unique case (seq_q)
            SeqPadL: begin
                if (hold_free) begin
                    col_d     = '0;
                    pad_d     = 1'b1;
                    control_d = 1'b1;
                    hold_d    = HoldFull;
                    seq_d     = SeqData;
                end
            end
            SeqData: begin
                if (hold_free && fill_full) begin
                    col_d     = fill_col;
                    pad_d     = 1'b0;
                    control_d = 1'b1;
                    hold_d    = HoldFull;
                    take      = 1'b1;
                    if (col_cnt_q == LastCol) begin
                        col_cnt_d = '0;
                        seq_d     = SeqPadR;
                    end else begin
                        col_cnt_d = col_cnt_q + ColW'(1);
                    end
                end
            end
            SeqPadR: begin
                if (hold_free) begin
                    col_d       = '0;
                    pad_d       = 1'b1;
                    control_d   = 1'b1;
                    frame_end_d = 1'b1;
                    hold_d      = HoldFull;
                    seq_d       = SeqPadL;
                end
            end
            default: begin
                seq_d = SeqPadL;
            end
        endcase

        // Ack without a competing load releases the hold; a load always wins.
        if (!control_d && i_col_ack && (hold_q == HoldFull)) begin
            hold_d = HoldEmpty;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            seq_q       <= SeqPadL;
            hold_q      <= HoldEmpty;
            col_q       <= '0;
            col_cnt_q   <= '0;
            pad_q       <= 1'b0;
            control_q   <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            seq_q       <= seq_d;
            hold_q      <= hold_d;
            col_q       <= col_d;
            col_cnt_q   <= col_cnt_d;
            pad_q       <= pad_d;
            control_q   <= control_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign o_col       = col_q;
    assign o_control   = control_q;
    assign o_col_pad   = pad_q;
    assign o_frame_end = frame_end_q;

endmodule

// File: tb/tb_column_assembler.sv
// Bench for column_assembler: directed columns are streamed in, the expected
// column sequence (pads and data) is queued as stimulus is issued, and a
// monitor pops and compares on every o_control pulse.
module tb_column_assembler;
    import column_assembler_pkg::*;

    localparam int H  = 120;
    localparam int NB = 7;
    localparam int W  = 4;
    localparam int CW = H * NB;

    logic          clock;
    logic          i_reset;
    logic [NB-1:0] i_pixel;
    logic          i_valid;
    logic          o_ready;
    logic [CW-1:0] o_col;
    logic          o_control;
    logic          o_col_pad;
    logic          o_frame_end;
    logic          i_col_ack;

    column_assembler #(
        .IMG_HEIGHT (H),
        .IMG_NB     (NB),
        .IMG_WIDTH  (W)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_pixel     (i_pixel),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_col       (o_col),
        .o_control   (o_control),
        .o_col_pad   (o_col_pad),
        .o_frame_end (o_frame_end),
        .i_col_ack   (i_col_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic          pad;
        logic          fe;
        logic [CW-1:0] col;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   pulses = 0;
    int   fe_at  = 0;
    int   dcount = 0;

    logic [CW-1:0] zero_col;
    logic [CW-1:0] c_d0, c_d1, c_d2, c_d3, c_r;

    function automatic logic [NB-1:0] pix(input logic [CW-1:0] c, input int r);
        return c[(H - r) * NB - 1 -: NB];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_col(input string name, input logic [CW-1:0] act,
                             input logic [CW-1:0] exp);
        int r;
        tests++;
        if (act !== exp) begin
            fails++;
            r = 0;
            while (r < H - 1 && pix(act, r) === pix(exp, r)) r++;
            $display("FAIL %s: row %0d got %0d expected %0d", name, r,
                     pix(act, r), pix(exp, r));
        end
    endtask

    task automatic push_exp(input logic pad, input logic fe, input logic [CW-1:0] col);
        exp_t e;
        e.pad = pad;
        e.fe  = fe;
        e.col = col;
        exp_q.push_back(e);
    endtask

    // Frame order: data columns, then right pad (frame end), then next left pad.
    task automatic push_data(input logic [CW-1:0] col);
        push_exp(1'b0, 1'b0, col);
        dcount++;
        if (dcount == W) begin
            push_exp(1'b1, 1'b1, zero_col);
            push_exp(1'b1, 1'b0, zero_col);
            dcount = 0;
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (!i_reset && o_control) begin
                pulses++;
                if (o_frame_end) fe_at = pulses;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", pulses, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_col("mon_col", o_col, e.col);
                    check("mon_pad", int'(o_col_pad), int'(e.pad));
                    check("mon_frame_end", int'(o_frame_end), int'(e.fe));
                end
            end
        end
    endtask

    task automatic send_pixel(input int v);
        int guard;
        guard   = 0;
        i_valid = 1'b1;
        i_pixel = v[NB-1:0];
        @(negedge clock);
        while (!o_ready && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        if (!o_ready) begin
            check("send_timeout", guard, 0);
        end
        @(posedge clock);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send_col(input int base, input int step, output logic [CW-1:0] col);
        int v;
        col = '0;
        for (int r = 0; r < H; r++) begin
            v = (base + r * step) & 127;
            col[(H - r) * NB - 1 -: NB] = v[NB-1:0];
            send_pixel(v);
        end
        push_data(col);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        i_reset = 1'b1;
        i_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_ready", int'(o_ready), 1);
        check("reset_control", int'(o_control), 0);
        check("reset_pad", int'(o_col_pad), 0);
        check("reset_frame_end", int'(o_frame_end), 0);
        check_col("reset_col", o_col, zero_col);
        exp_q.delete();
        dcount = 0;
        pulses = 0;
        fe_at  = 0;
        push_exp(1'b1, 1'b0, zero_col);
        @(posedge clock);
        #1;
        i_reset = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 2000) begin
            @(negedge clock);
            g++;
        end
        @(negedge clock);
        check("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        int bad;
        zero_col  = '0;
        i_reset   = 1'b1;
        i_valid   = 1'b0;
        i_pixel   = '0;
        i_col_ack = 1'b1;

        fork
            monitor();
            begin
                #2_000_000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset release with ack high: left pad in cycle 1.
        do_reset();
        @(posedge clock);
        #1;
        check("rst_release_control", int'(o_control), 1);
        check("rst_release_pad", int'(o_col_pad), 1);
        check_col("rst_release_col", o_col, zero_col);

        // Column of 1..120; pulse one cycle after the last pixel.
        send_col(1, 1, c_d0);
        @(posedge clock);
        #1;
        check("d0_control", int'(o_control), 1);
        check("d0_pad", int'(o_col_pad), 0);
        check("d0_msb_slice", int'(pix(o_col, 0)), 1);
        check("d0_lsb_slice", int'(pix(o_col, H - 1)), 120);
        repeat (3) @(posedge clock);
        #1;

        // Ack low: two columns; second stays in fill and stalls the stream.
        i_col_ack = 1'b0;
        send_col(5, 3, c_d1);
        send_col(100, 5, c_d2);
        bad = 0;
        repeat (8) begin
            @(negedge clock);
            if (o_ready) bad++;
        end
        check("ready_low_while_blocked", bad, 0);
        check_col("hold_keeps_d1", o_col, c_d1);

        // One-cycle ack: load of d2 wins over the ack.
        @(posedge clock);
        #1;
        i_col_ack = 1'b1;
        @(negedge clock);
        check("ready_high_on_ack", int'(o_ready), 1);
        @(posedge clock);
        #1;
        i_col_ack = 1'b0;
        check("ack_load_control", int'(o_control), 1);

        // Hold must still be full: a completed d3 must not load without ack.
        send_col(33, 11, c_d3);
        bad = 0;
        repeat (6) begin
            @(negedge clock);
            if (o_control) bad++;
        end
        check("no_pulse_while_held", bad, 0);
        check_col("hold_full_after_ack_load", o_col, c_d2);
        check("ready_low_d3", int'(o_ready), 0);

        // Release: d3, right pad with frame end, next left pad.
        @(posedge clock);
        #1;
        i_col_ack = 1'b1;
        wait_drain();
        check("frame_end_pulse_index", fe_at, 6);
        check("pulses_frame_plus_next_pad", pulses, 7);

        // Reset mid-column discards partial data.
        for (int k = 0; k < 50; k++) send_pixel(127);
        do_reset();
        @(posedge clock);
        #1;
        check("rst2_release_control", int'(o_control), 1);
        check("rst2_release_pad", int'(o_col_pad), 1);
        send_col(2, 2, c_r);
        @(posedge clock);
        #1;
        check("r_control", int'(o_control), 1);
        check("r_msb_slice", int'(pix(o_col, 0)), 2);
        wait_drain();
        check("pulses_after_reset", pulses, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
